// File: rtl/pcileech_tlps128_tx_arbiter.sv
// Packet-atomic weighted round-robin merge of two 128-bit TLP streams; 1-cycle registered output.
// Backpressure: m_tready low freezes the output slice and both s*_tready; only the stall watchdog may advance.
module pcileech_tlps128_tx_arbiter #(
    parameter int unsigned W0          = 2,
    parameter int unsigned W1          = 1,
    parameter logic [7:0]  STALL_LIMIT = 8'd255
) (
    input  logic         clk_pcie,
    input  logic         rst,
    input  logic [127:0] s0_tdata,
    input  logic [3:0]   s0_tkeepdw,
    input  logic         s0_tlast,
    input  logic [8:0]   s0_tuser,
    input  logic         s0_tvalid,
    output logic         s0_tready,
    input  logic [127:0] s1_tdata,
    input  logic [3:0]   s1_tkeepdw,
    input  logic         s1_tlast,
    input  logic [8:0]   s1_tuser,
    input  logic         s1_tvalid,
    output logic         s1_tready,
    output logic [127:0] m_tdata,
    output logic [3:0]   m_tkeepdw,
    output logic         m_tlast,
    output logic [8:0]   m_tuser,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [15:0]  pkt_cnt0,
    output logic [15:0]  pkt_cnt1,
    output logic         stall_err,
    output logic [1:0]   grant
);
    localparam logic [3:0] LP_W0 = 4'(W0);
    localparam logic [3:0] LP_W1 = 4'(W1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} state_t;

    state_t       r_state;
    logic         r_last_win;
    logic [3:0]   r_cons_cnt;
    logic [7:0]   r_stall_cnt;
    logic         r_stall_err;
    logic [15:0]  r_pkt_cnt0;
    logic [15:0]  r_pkt_cnt1;
    logic [127:0] r_tdata;
    logic [3:0]   r_tkeepdw;
    logic         r_tlast;
    logic [8:0]   r_tuser;
    logic         r_tvalid;

    logic         w_slot_free;
    logic [3:0]   w_weight;
    logic         w_repeat;
    logic         w_win;
    logic         w_xfer0;
    logic         w_xfer1;
    logic         w_xfer;
    logic         w_src;
    logic         w_tlast;
    logic         w_done;
    logic         w_locked_vld;
    logic [7:0]   w_stall_nxt;

    assign w_slot_free = !r_tvalid || m_tready;
    assign w_weight    = r_last_win ? LP_W1 : LP_W0;
    // A zero streak means nobody has completed yet, so the opposite source gets the first turn.
    assign w_repeat    = (r_cons_cnt != 4'd0) && (r_cons_cnt < w_weight);

    always_comb begin
        w_win = s1_tvalid;
        if (s0_tvalid && s1_tvalid)
            w_win = w_repeat ? r_last_win : !r_last_win;
    end

    assign s0_tready = w_slot_free && ((r_state == ST_LOCK0) ||
                       ((r_state == ST_IDLE) && s0_tvalid && !w_win));
    assign s1_tready = w_slot_free && ((r_state == ST_LOCK1) ||
                       ((r_state == ST_IDLE) && s1_tvalid && w_win));

    assign w_xfer0 = s0_tvalid && s0_tready;
    assign w_xfer1 = s1_tvalid && s1_tready;
    assign w_xfer  = w_xfer0 || w_xfer1;
    assign w_src   = w_xfer1;
    assign w_tlast = w_src ? s1_tlast : s0_tlast;
    assign w_done  = w_xfer && w_tlast;

    assign w_locked_vld = (r_state == ST_LOCK1) ? s1_tvalid : s0_tvalid;

    always_comb begin
        w_stall_nxt = r_stall_cnt;
        if ((r_state == ST_IDLE) || w_xfer)
            w_stall_nxt = 8'd0;
        else if (!w_locked_vld && (r_stall_cnt != STALL_LIMIT))
            w_stall_nxt = r_stall_cnt + 8'd1;
    end

    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_win  <= 1'b1;
            r_cons_cnt  <= 4'd0;
            r_stall_cnt <= 8'd0;
            r_stall_err <= 1'b0;
            r_pkt_cnt0  <= 16'd0;
            r_pkt_cnt1  <= 16'd0;
            r_tdata     <= 128'd0;
            r_tkeepdw   <= 4'd0;
            r_tlast     <= 1'b0;
            r_tuser     <= 9'd0;
            r_tvalid    <= 1'b0;
        end else begin
            if (w_slot_free) begin
                r_tvalid <= w_xfer;
                if (w_xfer) begin
                    r_tdata   <= w_src ? s1_tdata   : s0_tdata;
                    r_tkeepdw <= w_src ? s1_tkeepdw : s0_tkeepdw;
                    r_tlast   <= w_tlast;
                    r_tuser   <= w_src ? s1_tuser   : s0_tuser;
                end
            end

            case (r_state)
                ST_IDLE:  if (w_xfer && !w_tlast) r_state <= w_src ? ST_LOCK1 : ST_LOCK0;
                ST_LOCK0,
                ST_LOCK1: if (w_done) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase

            if (w_done) begin
                if (w_src == r_last_win) begin
                    if (r_cons_cnt != 4'd15) r_cons_cnt <= r_cons_cnt + 4'd1;
                end else begin
                    r_cons_cnt <= 4'd1;
                    r_last_win <= w_src;
                end
                if (!w_src && (r_pkt_cnt0 != 16'hFFFF)) r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
                if (w_src && (r_pkt_cnt1 != 16'hFFFF))  r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
            end

            r_stall_cnt <= w_stall_nxt;
            if ((r_state != ST_IDLE) && (w_stall_nxt == STALL_LIMIT))
                r_stall_err <= 1'b1;
        end
    end

    assign m_tdata   = r_tdata;
    assign m_tkeepdw = r_tkeepdw;
    assign m_tlast   = r_tlast;
    assign m_tuser   = r_tuser;
    assign m_tvalid  = r_tvalid;
    assign pkt_cnt0  = r_pkt_cnt0;
    assign pkt_cnt1  = r_pkt_cnt1;
    assign stall_err = r_stall_err;
    assign grant     = {r_state == ST_LOCK1, r_state == ST_LOCK0};
endmodule

// File: tb/tb_pcileech_tlps128_tx_arbiter.sv
// Directed bench for the two-source TLP transmit arbiter (W0=2, W1=1, STALL_LIMIT=8).
module tb_pcileech_tlps128_tx_arbiter;
    logic         clk_pcie = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] s0_tdata = '0;
    logic [3:0]   s0_tkeepdw = '0;
    logic         s0_tlast = 1'b0;
    logic [8:0]   s0_tuser = '0;
    logic         s0_tvalid = 1'b0;
    logic         s0_tready;
    logic [127:0] s1_tdata = '0;
    logic [3:0]   s1_tkeepdw = '0;
    logic         s1_tlast = 1'b0;
    logic [8:0]   s1_tuser = '0;
    logic         s1_tvalid = 1'b0;
    logic         s1_tready;
    logic [127:0] m_tdata;
    logic [3:0]   m_tkeepdw;
    logic         m_tlast;
    logic [8:0]   m_tuser;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [15:0]  pkt_cnt0;
    logic [15:0]  pkt_cnt1;
    logic         stall_err;
    logic [1:0]   grant;

    int n_chk = 0;
    int n_bad = 0;

    pcileech_tlps128_tx_arbiter #(.W0(2), .W1(1), .STALL_LIMIT(8'd8)) dut (
        .clk_pcie(clk_pcie), .rst(rst),
        .s0_tdata(s0_tdata), .s0_tkeepdw(s0_tkeepdw), .s0_tlast(s0_tlast),
        .s0_tuser(s0_tuser), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tkeepdw(s1_tkeepdw), .s1_tlast(s1_tlast),
        .s1_tuser(s1_tuser), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tkeepdw(m_tkeepdw), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .stall_err(stall_err), .grant(grant)
    );

    always #5 clk_pcie = ~clk_pcie;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int src, input int idx);
        return {96'hDEAD_BEEF_CAFE_F00D_1234_5678, 8'(src), 8'(idx), 16'h5A5A};
    endfunction

    task automatic tick();
        @(posedge clk_pcie);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        // reset state
        chk("rst_mvalid", 128'(m_tvalid), 128'd0);
        chk("rst_grant", 128'(grant), 128'd0);
        chk("rst_cnt0", 128'(pkt_cnt0), 128'd0);
        chk("rst_cnt1", 128'(pkt_cnt1), 128'd0);
        chk("rst_err", 128'(stall_err), 128'd0);
        rst = 1'b0;
        tick();

        // 1: single 1-beat cfg completion from src0
        s0_tdata = mk(0, 1); s0_tkeepdw = 4'b0111; s0_tlast = 1'b1; s0_tuser = 9'h001; s0_tvalid = 1'b1;
        #1;
        chk("t1_s0rdy", 128'(s0_tready), 128'd1);
        chk("t1_mvalid_pre", 128'(m_tvalid), 128'd0);
        tick();
        s0_tvalid = 1'b0;
        chk("t1_mvalid", 128'(m_tvalid), 128'd1);
        chk("t1_mdata", m_tdata, mk(0, 1));
        chk("t1_mkeep", 128'(m_tkeepdw), 128'h7);
        chk("t1_mlast", 128'(m_tlast), 128'd1);
        chk("t1_muser", 128'(m_tuser), 128'h001);
        chk("t1_cnt0", 128'(pkt_cnt0), 128'd1);
        chk("t1_grant", 128'(grant), 128'd0);
        tick();
        chk("t1_mvalid_off", 128'(m_tvalid), 128'd0);

        // 2: contention, expected order 0,0,1 repeating
        do_reset();
        s0_tlast = 1'b1; s1_tlast = 1'b1; s0_tvalid = 1'b1; s1_tvalid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s0_tdata = mk(0, 16 + i);
            s1_tdata = mk(1, 16 + i);
            tick();
            chk("t2_order", m_tdata, (i % 3 == 2) ? mk(1, 16 + i) : mk(0, 16 + i));
        end
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        tick();
        chk("t2_cnt0", 128'(pkt_cnt0), 128'd6);
        chk("t2_cnt1", 128'(pkt_cnt1), 128'd3);

        // 3: src1 3-beat packet, src0 joins at beat 2
        s1_tdata = mk(1, 48); s1_tlast = 1'b0; s1_tvalid = 1'b1;
        tick();
        chk("t3_b0", m_tdata, mk(1, 48));
        s1_tdata = mk(1, 49);
        s0_tdata = mk(0, 50); s0_tlast = 1'b1; s0_tvalid = 1'b1;
        #1;
        chk("t3_s0blk_b1", 128'(s0_tready), 128'd0);
        chk("t3_grant_b1", 128'(grant), 128'b10);
        tick();
        chk("t3_b1", m_tdata, mk(1, 49));
        s1_tdata = mk(1, 51); s1_tlast = 1'b1;
        #1;
        chk("t3_s0blk_b2", 128'(s0_tready), 128'd0);
        chk("t3_grant_b2", 128'(grant), 128'b10);
        tick();
        chk("t3_b2", m_tdata, mk(1, 51));
        s1_tvalid = 1'b0;
        #1;
        chk("t3_s0rdy", 128'(s0_tready), 128'd1);
        tick();
        s0_tvalid = 1'b0;
        chk("t3_s0pkt", m_tdata, mk(0, 50));
        chk("t3_nobubble", 128'(m_tvalid), 128'd1);

        // 4: backpressure mid-packet for 10 cycles
        s0_tdata = mk(0, 64); s0_tlast = 1'b0; s0_tvalid = 1'b1;
        tick();
        chk("t4_b0", m_tdata, mk(0, 64));
        s0_tdata = mk(0, 65);
        s1_tdata = mk(1, 66); s1_tlast = 1'b1; s1_tvalid = 1'b1;
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t4_s0hold", 128'(s0_tready), 128'd0);
            chk("t4_s1hold", 128'(s1_tready), 128'd0);
            tick();
            chk("t4_mstable", m_tdata, mk(0, 64));
            chk("t4_mvalid", 128'(m_tvalid), 128'd1);
        end
        m_tready = 1'b1;
        tick();
        chk("t4_b1", m_tdata, mk(0, 65));
        s0_tdata = mk(0, 67); s0_tlast = 1'b1;
        tick();
        chk("t4_b2", m_tdata, mk(0, 67));
        s0_tvalid = 1'b0;
        tick();
        s1_tvalid = 1'b0;
        chk("t4_s1pkt", m_tdata, mk(1, 66));
        chk("t4_err", 128'(stall_err), 128'd0);
        chk("t4_cnt1", 128'(pkt_cnt1), 128'd5);

        // 5: stall watchdog
        s0_tdata = mk(0, 80); s0_tlast = 1'b0; s0_tvalid = 1'b1;
        tick();
        s0_tvalid = 1'b0;
        s1_tdata = mk(1, 81); s1_tlast = 1'b0; s1_tvalid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("t5_s1blk", 128'(s1_tready), 128'd0);
            chk("t5_grant", 128'(grant), 128'b01);
            tick();
            chk("t5_err", 128'(stall_err), (i == 8) ? 128'd1 : 128'd0);
        end
        s0_tdata = mk(0, 82); s0_tlast = 1'b1; s0_tvalid = 1'b1;
        #1;
        chk("t5_s0rdy", 128'(s0_tready), 128'd1);
        tick();
        s0_tvalid = 1'b0;
        chk("t5_b1", m_tdata, mk(0, 82));
        chk("t5_idle", 128'(grant), 128'd0);
        chk("t5_sticky", 128'(stall_err), 128'd1);
        chk("t5_cnt0", 128'(pkt_cnt0), 128'd9);

        // 6: reset during LOCK1 with m_tvalid high
        tick();
        chk("t6_lock1", 128'(grant), 128'b10);
        chk("t6_mvalid", 128'(m_tvalid), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_mvalid", 128'(m_tvalid), 128'd0);
        chk("t6_rst_grant", 128'(grant), 128'd0);
        chk("t6_rst_cnt0", 128'(pkt_cnt0), 128'd0);
        chk("t6_rst_cnt1", 128'(pkt_cnt1), 128'd0);
        chk("t6_rst_err", 128'(stall_err), 128'd0);
        rst = 1'b0;
        s0_tdata = mk(0, 96); s0_tlast = 1'b1; s0_tvalid = 1'b1;
        s1_tdata = mk(1, 97); s1_tlast = 1'b1; s1_tvalid = 1'b1;
        #1;
        chk("t6_s0win", 128'(s0_tready), 128'd1);
        chk("t6_s1lose", 128'(s1_tready), 128'd0);
        tick();
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        chk("t6_first", m_tdata, mk(0, 96));
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
